// File: rtl/axi_wr_arbiter_if.sv
// axi_wr_arbiter_if: requester-side and memory-side AXI write signals; master = arbiter view, slave = environment view
interface axi_wr_arbiter_if #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 34,
  parameter int ID_WIDTH   = 8
);
  logic [PORTS*ADDR_WIDTH-1:0] s_axi_awaddr;
  logic [PORTS-1:0]            s_axi_awvalid;
  logic [PORTS-1:0]            s_axi_awready;
  logic [PORTS*DATA_WIDTH-1:0] s_axi_wdata;
  logic [PORTS*KEEP_WIDTH-1:0] s_axi_wstrb;
  logic [PORTS-1:0]            s_axi_wvalid;
  logic [PORTS-1:0]            s_axi_wready;
  logic [PORTS*2-1:0]          s_axi_bresp;
  logic [PORTS-1:0]            s_axi_bvalid;
  logic [PORTS-1:0]            s_axi_bready;
  logic [ID_WIDTH-1:0]         m_axi_awid;
  logic [ADDR_WIDTH-1:0]       m_axi_awaddr;
  logic [7:0]                  m_axi_awlen;
  logic [2:0]                  m_axi_awsize;
  logic [1:0]                  m_axi_awburst;
  logic                        m_axi_awvalid;
  logic                        m_axi_awready;
  logic [DATA_WIDTH-1:0]       m_axi_wdata;
  logic [KEEP_WIDTH-1:0]       m_axi_wstrb;
  logic                        m_axi_wlast;
  logic                        m_axi_wvalid;
  logic                        m_axi_wready;
  logic [ID_WIDTH-1:0]         m_axi_bid;
  logic [1:0]                  m_axi_bresp;
  logic                        m_axi_bvalid;
  logic                        m_axi_bready;
  modport master (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
    input  m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready
  );
  modport slave (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
    output m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready
  );
endinterface

// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: round-robin share of one AXI4 write master among PORTS single-beat requesters (clk, rst_n, bus, busy, grant_idx; resp_err_* with AXI_WR_ARB_RESP_CHECK_EN)
module axi_wr_arbiter #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 34,
  parameter int ID_WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  axi_wr_arbiter_if.master           bus,
  output logic                       busy,
  output logic [$clog2(PORTS)-1:0]   grant_idx
`ifdef AXI_WR_ARB_RESP_CHECK_EN
  ,
  output logic                       resp_err_sticky,
  output logic [$clog2(PORTS)-1:0]   resp_err_port,
  output logic [15:0]                resp_err_count
`endif
);
  localparam int GW = $clog2(PORTS);
  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
  state_t        state_q;
  logic [GW-1:0] grant_q, last_q, pick_d, cand;
  logic          found_d, aw_done_q, w_done_q, aw_hs, w_hs, b_hs, xfer, resp;
  assign xfer      = state_q == XFER;
  assign resp      = state_q == RESP;
  assign busy      = state_q != IDLE;
  assign grant_idx = grant_q;
  // first awvalid found scanning upward from the port after the last granted one
  always_comb begin
    found_d = 1'b0;
    pick_d  = grant_q;
    cand    = '0;
    for (int k = 1; k <= PORTS; k++) begin
      cand = GW'((int'(last_q) + k) % PORTS);
      if (!found_d && bus.s_axi_awvalid[cand]) begin
        found_d = 1'b1;
        pick_d  = cand;
      end
    end
  end
  always_comb begin
    bus.s_axi_awready                = '0;
    bus.s_axi_wready                 = '0;
    bus.s_axi_bvalid                 = '0;
    bus.s_axi_bresp                  = '0;
    bus.m_axi_awvalid                = xfer & bus.s_axi_awvalid[grant_q] & ~aw_done_q;
    bus.m_axi_wvalid                 = xfer & bus.s_axi_wvalid[grant_q] & ~w_done_q;
    bus.m_axi_bready                 = resp & bus.s_axi_bready[grant_q];
    bus.s_axi_awready[grant_q]       = xfer & bus.m_axi_awready & ~aw_done_q;
    bus.s_axi_wready[grant_q]        = xfer & bus.m_axi_wready & ~w_done_q;
    bus.s_axi_bvalid[grant_q]        = resp & bus.m_axi_bvalid;
    bus.s_axi_bresp[grant_q*2 +: 2]  = resp ? bus.m_axi_bresp : 2'b00;
  end
  assign bus.m_axi_awid    = ID_WIDTH'(grant_q);
  assign bus.m_axi_awaddr  = bus.s_axi_awaddr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
  assign bus.m_axi_wdata   = bus.s_axi_wdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign bus.m_axi_wstrb   = bus.s_axi_wstrb[grant_q*KEEP_WIDTH +: KEEP_WIDTH];
  assign bus.m_axi_awlen   = 8'd0;
  assign bus.m_axi_awsize  = 3'($clog2(KEEP_WIDTH));
  assign bus.m_axi_awburst = 2'b01;
  assign bus.m_axi_wlast   = 1'b1;
  assign aw_hs = bus.m_axi_awvalid & bus.m_axi_awready;
  assign w_hs  = bus.m_axi_wvalid & bus.m_axi_wready;
  assign b_hs  = bus.m_axi_bready & bus.m_axi_bvalid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= GW'(PORTS - 1);
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (found_d) begin
          grant_q <= pick_d;
          state_q <= XFER;
        end
        XFER: if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          state_q   <= RESP;
        end else begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs) w_done_q <= 1'b1;
        end
        RESP: if (b_hs) begin
          last_q  <= grant_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef AXI_WR_ARB_RESP_CHECK_EN
  logic          err_sticky_q, b_err;
  logic [GW-1:0] err_port_q;
  logic [15:0]   err_cnt_q;
  assign b_err           = (bus.m_axi_bresp != 2'b00) || (bus.m_axi_bid != ID_WIDTH'(grant_q));
  assign resp_err_sticky = err_sticky_q;
  assign resp_err_port   = err_port_q;
  assign resp_err_count  = err_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
      err_port_q   <= '0;
      err_cnt_q    <= '0;
    end else if (b_hs && b_err) begin
      err_sticky_q <= 1'b1;
      if (!err_sticky_q) err_port_q <= grant_q;
      if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb_axi_wr_arbiter: directed self-checking bench for axi_wr_arbiter (4 ports, 32-bit data)
module tb_axi_wr_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [1:0] grant_idx;
  int         passed = 0;
  int         total = 0;
`ifdef AXI_WR_ARB_RESP_CHECK_EN
  logic        resp_err_sticky;
  logic [1:0]  resp_err_port;
  logic [15:0] resp_err_count;
`endif
  axi_wr_arbiter_if #(.PORTS(4), .DATA_WIDTH(32), .ADDR_WIDTH(34), .ID_WIDTH(8)) bus ();
  axi_wr_arbiter #(.PORTS(4), .DATA_WIDTH(32), .ADDR_WIDTH(34), .ID_WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .busy(busy),
    .grant_idx(grant_idx)
`ifdef AXI_WR_ARB_RESP_CHECK_EN
    ,
    .resp_err_sticky(resp_err_sticky),
    .resp_err_port(resp_err_port),
    .resp_err_count(resp_err_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic clear_inputs;
    bus.s_axi_awaddr  = '0;
    bus.s_axi_awvalid = '0;
    bus.s_axi_wdata   = '0;
    bus.s_axi_wstrb   = '0;
    bus.s_axi_wvalid  = '0;
    bus.s_axi_bready  = '0;
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;
    bus.m_axi_bid     = '0;
    bus.m_axi_bresp   = '0;
    bus.m_axi_bvalid  = 1'b0;
  endtask
  task automatic do_reset;
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask
  task automatic test_reset;
    clear_inputs();
    bus.s_axi_awvalid = 4'b0100;
    bus.s_axi_wvalid  = 4'b0100;
    bus.s_axi_bready  = 4'hF;
    bus.m_axi_awready = 1'b1;
    bus.m_axi_wready  = 1'b1;
    bus.m_axi_bvalid  = 1'b1;
    rst_n = 1'b0;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    total++; if (grant_idx !== 2'd0) $display("FAIL reset_grant got=%0d exp=0", grant_idx); else passed++;
    total++; if (bus.m_axi_awvalid !== 1'b0) $display("FAIL reset_awvalid got=%b exp=0", bus.m_axi_awvalid); else passed++;
    total++; if (bus.m_axi_wvalid !== 1'b0) $display("FAIL reset_wvalid got=%b exp=0", bus.m_axi_wvalid); else passed++;
    total++; if (bus.m_axi_bready !== 1'b0) $display("FAIL reset_bready got=%b exp=0", bus.m_axi_bready); else passed++;
    total++; if (bus.s_axi_awready !== 4'b0) $display("FAIL reset_s_awready got=%b exp=0000", bus.s_axi_awready); else passed++;
    total++; if (bus.s_axi_wready !== 4'b0) $display("FAIL reset_s_wready got=%b exp=0000", bus.s_axi_wready); else passed++;
    total++; if (bus.s_axi_bvalid !== 4'b0) $display("FAIL reset_s_bvalid got=%b exp=0000", bus.s_axi_bvalid); else passed++;
    total++; if (bus.s_axi_bresp !== 8'b0) $display("FAIL reset_s_bresp got=%b exp=0", bus.s_axi_bresp); else passed++;
`ifdef AXI_WR_ARB_RESP_CHECK_EN
    total++; if (resp_err_sticky !== 1'b0) $display("FAIL reset_err_sticky got=%b exp=0", resp_err_sticky); else passed++;
    total++; if (resp_err_count !== 16'd0) $display("FAIL reset_err_count got=%0d exp=0", resp_err_count); else passed++;
`endif
  endtask
  task automatic test_single;
    do_reset();
    bus.m_axi_awready = 1'b1;
    bus.m_axi_wready  = 1'b1;
    bus.s_axi_bready  = 4'hF;
    bus.s_axi_awaddr[2*34 +: 34] = 34'h1000;
    bus.s_axi_wdata[2*32 +: 32]  = 32'hA5A5_0002;
    bus.s_axi_wstrb[2*4 +: 4]    = 4'hF;
    bus.s_axi_awvalid = 4'b0100;
    bus.s_axi_wvalid  = 4'b0100;
    #1;
    total++; if (bus.m_axi_awvalid !== 1'b0) $display("FAIL single_idle_awvalid got=%b exp=0", bus.m_axi_awvalid); else passed++;
    tick();
    total++; if (grant_idx !== 2'd2) $display("FAIL single_grant got=%0d exp=2", grant_idx); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL single_busy got=%b exp=1", busy); else passed++;
    total++; if (bus.m_axi_awvalid !== 1'b1 || bus.m_axi_wvalid !== 1'b1) $display("FAIL single_valids got=%b%b exp=11", bus.m_axi_awvalid, bus.m_axi_wvalid); else passed++;
    total++; if (bus.m_axi_awid !== 8'd2) $display("FAIL single_awid got=%0d exp=2", bus.m_axi_awid); else passed++;
    total++; if (bus.m_axi_awaddr !== 34'h1000) $display("FAIL single_awaddr got=%h exp=1000", bus.m_axi_awaddr); else passed++;
    total++; if (bus.m_axi_wdata !== 32'hA5A5_0002 || bus.m_axi_wstrb !== 4'hF) $display("FAIL single_wpayload got=%h/%h exp=a5a50002/f", bus.m_axi_wdata, bus.m_axi_wstrb); else passed++;
    total++; if ({bus.m_axi_wlast, bus.m_axi_awlen, bus.m_axi_awsize, bus.m_axi_awburst} !== {1'b1, 8'd0, 3'd2, 2'b01}) $display("FAIL single_consts got=%b/%0d/%0d/%b exp=1/0/2/01", bus.m_axi_wlast, bus.m_axi_awlen, bus.m_axi_awsize, bus.m_axi_awburst); else passed++;
    total++; if (bus.s_axi_awready !== 4'b0100 || bus.s_axi_wready !== 4'b0100) $display("FAIL single_readies got=%b/%b exp=0100/0100", bus.s_axi_awready, bus.s_axi_wready); else passed++;
    tick();
    bus.s_axi_awvalid = 4'b0;
    bus.s_axi_wvalid  = 4'b0;
    #1;
    total++; if (bus.m_axi_bready !== 1'b1 || bus.m_axi_awvalid !== 1'b0) $display("FAIL single_resp_state got=bready%b awvalid%b exp=1/0", bus.m_axi_bready, bus.m_axi_awvalid); else passed++;
    total++; if (bus.s_axi_bvalid !== 4'b0) $display("FAIL single_bvalid_early got=%b exp=0000", bus.s_axi_bvalid); else passed++;
    bus.m_axi_bvalid = 1'b1;
    bus.m_axi_bid    = 8'd2;
    #1;
    total++; if (bus.s_axi_bvalid !== 4'b0100 || bus.s_axi_bresp !== 8'b0) $display("FAIL single_bvalid got=%b/%b exp=0100/0", bus.s_axi_bvalid, bus.s_axi_bresp); else passed++;
    tick();
    bus.m_axi_bvalid = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || grant_idx !== 2'd2) $display("FAIL single_done got=busy%b grant%0d exp=0/2", busy, grant_idx); else passed++;
    total++; if (bus.s_axi_bvalid !== 4'b0) $display("FAIL single_bvalid_after got=%b exp=0000", bus.s_axi_bvalid); else passed++;
  endtask
  task automatic test_round_robin;
    int got[5];
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    int n = 0;
    int first_c = 0;
    int last_c = 0;
    do_reset();
    bus.s_axi_awvalid = 4'hF;
    bus.s_axi_wvalid  = 4'hF;
    bus.s_axi_bready  = 4'hF;
    bus.m_axi_awready = 1'b1;
    bus.m_axi_wready  = 1'b1;
    bus.m_axi_bvalid  = 1'b1;
    for (int c = 0; c < 40 && n < 5; c++) begin
      tick();
      if (|bus.s_axi_bvalid) begin
        total++; if (bus.s_axi_bvalid !== (4'b0001 << grant_idx)) $display("FAIL rr_bvalid_onehot got=%b grant=%0d", bus.s_axi_bvalid, grant_idx); else passed++;
        got[n] = int'(grant_idx);
        if (n == 0) first_c = c;
        last_c = c;
        n++;
      end
    end
    total++; if (n != 5) $display("FAIL rr_timeout got=%0d responses exp=5", n); else passed++;
    for (int i = 0; i < 5; i++) begin
      total++; if (got[i] != exp_seq[i]) $display("FAIL rr_seq%0d got=%0d exp=%0d", i, got[i], exp_seq[i]); else passed++;
    end
    total++; if (last_c - first_c != 12) $display("FAIL rr_throughput got=%0d cycles exp=12", last_c - first_c); else passed++;
    clear_inputs();
  endtask
  task automatic test_w_before_aw;
    do_reset();
    bus.m_axi_wready  = 1'b1;
    bus.s_axi_bready  = 4'hF;
    bus.s_axi_awaddr[1*34 +: 34] = 34'h2_0000_0040;
    bus.s_axi_wdata[1*32 +: 32]  = 32'h1111_2222;
    bus.s_axi_wstrb[1*4 +: 4]    = 4'h3;
    bus.s_axi_wvalid  = 4'b0010;
    tick();
    tick();
    tick();
    total++; if (busy !== 1'b0 || bus.s_axi_wready !== 4'b0) $display("FAIL wfirst_idle got=busy%b wready%b exp=0/0000", busy, bus.s_axi_wready); else passed++;
    bus.s_axi_awvalid = 4'b0010;
    tick();
    total++; if (grant_idx !== 2'd1) $display("FAIL wfirst_grant got=%0d exp=1", grant_idx); else passed++;
    total++; if (bus.m_axi_wvalid !== 1'b1 || bus.s_axi_wready !== 4'b0010) $display("FAIL wfirst_w got=%b/%b exp=1/0010", bus.m_axi_wvalid, bus.s_axi_wready); else passed++;
    total++; if (bus.m_axi_awvalid !== 1'b1 || bus.s_axi_awready !== 4'b0) $display("FAIL wfirst_aw_wait got=%b/%b exp=1/0000", bus.m_axi_awvalid, bus.s_axi_awready); else passed++;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.m_axi_awvalid !== 1'b1) $display("FAIL wfirst_awvalid_hold%0d got=%b exp=1", i, bus.m_axi_awvalid); else passed++;
      total++; if (bus.m_axi_wvalid !== 1'b0 || bus.s_axi_wready !== 4'b0) $display("FAIL wfirst_no_second_w%0d got=%b/%b exp=0/0000", i, bus.m_axi_wvalid, bus.s_axi_wready); else passed++;
    end
    bus.m_axi_awready = 1'b1;
    #1;
    total++; if (bus.s_axi_awready !== 4'b0010 || bus.m_axi_bready !== 1'b0) $display("FAIL wfirst_aw_hs got=%b/bready%b exp=0010/0", bus.s_axi_awready, bus.m_axi_bready); else passed++;
    tick();
    total++; if (busy !== 1'b1 || bus.m_axi_bready !== 1'b1 || bus.m_axi_awvalid !== 1'b0) $display("FAIL wfirst_resp got=busy%b bready%b awvalid%b exp=1/1/0", busy, bus.m_axi_bready, bus.m_axi_awvalid); else passed++;
    bus.s_axi_awvalid = 4'b0;
    bus.s_axi_wvalid  = 4'b0;
    bus.m_axi_bvalid  = 1'b1;
    bus.m_axi_bid     = 8'd1;
    #1;
    total++; if (bus.s_axi_bvalid !== 4'b0010) $display("FAIL wfirst_bvalid got=%b exp=0010", bus.s_axi_bvalid); else passed++;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL wfirst_done got=%b exp=0", busy); else passed++;
    clear_inputs();
  endtask
  task automatic test_reset_mid;
    do_reset();
    bus.s_axi_awvalid = 4'b1000;
    bus.s_axi_bready  = 4'hF;
    bus.m_axi_awready = 1'b1;
    bus.m_axi_wready  = 1'b1;
    bus.m_axi_bvalid  = 1'b1;
    tick();
    total++; if (grant_idx !== 2'd3 || bus.m_axi_awvalid !== 1'b1) $display("FAIL rmid_xfer got=grant%0d awvalid%b exp=3/1", grant_idx, bus.m_axi_awvalid); else passed++;
    total++; if (bus.m_axi_bready !== 1'b0 || bus.s_axi_bvalid !== 4'b0) $display("FAIL rmid_b_ignored got=bready%b bvalid%b exp=0/0000", bus.m_axi_bready, bus.s_axi_bvalid); else passed++;
    tick();
    bus.s_axi_wvalid = 4'b1000;
    #1;
    total++; if (bus.m_axi_awvalid !== 1'b0 || bus.m_axi_wvalid !== 1'b1 || busy !== 1'b1) $display("FAIL rmid_aw_done got=aw%b w%b busy%b exp=0/1/1", bus.m_axi_awvalid, bus.m_axi_wvalid, busy); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (bus.m_axi_wvalid !== 1'b0 || bus.m_axi_awvalid !== 1'b0 || busy !== 1'b0) $display("FAIL rmid_async got=aw%b w%b busy%b exp=0/0/0", bus.m_axi_awvalid, bus.m_axi_wvalid, busy); else passed++;
    total++; if (bus.s_axi_wready !== 4'b0 || grant_idx !== 2'd0) $display("FAIL rmid_async_state got=wready%b grant%0d exp=0000/0", bus.s_axi_wready, grant_idx); else passed++;
    bus.s_axi_awvalid = 4'b1001;
    bus.s_axi_wvalid  = 4'b1001;
    rst_n = 1'b1;
    tick();
    total++; if (grant_idx !== 2'd0 || bus.s_axi_bvalid !== 4'b0) $display("FAIL rmid_priority got=grant%0d bvalid%b exp=0/0000", grant_idx, bus.s_axi_bvalid); else passed++;
    tick();
    total++; if (bus.s_axi_bvalid !== 4'b0001) $display("FAIL rmid_no_stale_b got=%b exp=0001", bus.s_axi_bvalid); else passed++;
    clear_inputs();
    tick();
  endtask
  task automatic test_resp_check;
    do_reset();
    bus.s_axi_bready  = 4'hF;
    bus.m_axi_awready = 1'b1;
    bus.m_axi_wready  = 1'b1;
    bus.m_axi_bvalid  = 1'b1;
    bus.m_axi_bresp   = 2'b10;
    bus.m_axi_bid     = 8'd3;
    bus.s_axi_awvalid = 4'b1000;
    bus.s_axi_wvalid  = 4'b1000;
    tick();
    tick();
    bus.s_axi_awvalid = 4'b0;
    bus.s_axi_wvalid  = 4'b0;
    #1;
    total++; if (bus.s_axi_bresp !== 8'b1000_0000 || bus.s_axi_bvalid !== 4'b1000) $display("FAIL rchk_bresp3 got=%b/%b exp=10000000/1000", bus.s_axi_bresp, bus.s_axi_bvalid); else passed++;
    tick();
`ifdef AXI_WR_ARB_RESP_CHECK_EN
    total++; if (resp_err_sticky !== 1'b1 || resp_err_port !== 2'd3 || resp_err_count !== 16'd1) $display("FAIL rchk_first got=%b/%0d/%0d exp=1/3/1", resp_err_sticky, resp_err_port, resp_err_count); else passed++;
`endif
    bus.m_axi_bresp   = 2'b00;
    bus.m_axi_bid     = 8'd5;
    bus.s_axi_awvalid = 4'b0010;
    bus.s_axi_wvalid  = 4'b0010;
    tick();
    tick();
    bus.s_axi_awvalid = 4'b0;
    bus.s_axi_wvalid  = 4'b0;
    #1;
    total++; if (bus.s_axi_bresp !== 8'b0 || bus.s_axi_bvalid !== 4'b0010) $display("FAIL rchk_bresp1 got=%b/%b exp=0/0010", bus.s_axi_bresp, bus.s_axi_bvalid); else passed++;
    tick();
`ifdef AXI_WR_ARB_RESP_CHECK_EN
    total++; if (resp_err_sticky !== 1'b1 || resp_err_port !== 2'd3 || resp_err_count !== 16'd2) $display("FAIL rchk_second got=%b/%0d/%0d exp=1/3/2", resp_err_sticky, resp_err_port, resp_err_count); else passed++;
`endif
    clear_inputs();
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_w_before_aw();
    test_reset_mid();
    test_resp_check();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview:
- Round-robin arbiter sharing one AXI4 write master port between PORTS single-beat AXI write requesters.
- Requesters are AXIS-to-memory-map bridges issuing awlen=0 writes.
- Sits between the bridge instances and the memory interconnect.
- One transaction in flight at a time: AW/W forwarding and B-response routing by grant.

Parameters:
- PORTS, 4: number of requester ports, 2..16.
- DATA_WIDTH, 512: W data width in bits.
- KEEP_WIDTH, DATA_WIDTH/8: write strobe width.
- ADDR_WIDTH, 34: address width.
- ID_WIDTH, 8: master AWID/BID width; must satisfy 2^ID_WIDTH >= PORTS.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- s_axi_awaddr  in  PORTS*ADDR_WIDTH  per-port write address, flattened, port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- s_axi_awvalid / s_axi_awready  in / out  PORTS  per-port AW handshake.
- s_axi_wdata  in  PORTS*DATA_WIDTH  per-port write data.
- s_axi_wstrb  in  PORTS*KEEP_WIDTH  per-port write strobes.
- s_axi_wvalid / s_axi_wready  in / out  PORTS  per-port W handshake.
- s_axi_bresp  out  PORTS*2  per-port write response.
- s_axi_bvalid / s_axi_bready  out / in  PORTS  per-port B handshake.
- m_axi_awid / m_axi_awaddr  out  ID_WIDTH / ADDR_WIDTH  master ID and address.
- m_axi_awlen/awsize/awburst  out  8/3/2  constants: 0, clog2(KEEP_WIDTH), INCR (2'b01).
- m_axi_awvalid / m_axi_awready  out / in  1  master AW handshake.
- m_axi_wdata / m_axi_wstrb / m_axi_wlast  out  DATA_WIDTH/KEEP_WIDTH/1  master W payload; wlast is tied to 1.
- m_axi_wvalid / m_axi_wready  out / in  1  master W handshake.
- m_axi_bid / m_axi_bresp / m_axi_bvalid  in  ID_WIDTH/2/1  master write response.
- m_axi_bready  out  1  master B ready.
- busy  out  1  high whenever state != IDLE.
- grant_idx  out  clog2(PORTS)  registered index of the current or last granted port.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; grant_idx=0; last-grant pointer=PORTS-1, so port 0 has first priority.
  - aw_done=0, w_done=0.
  - All outputs low: valids, readies, busy. s_axi_bresp=0.
- Reset mid-transaction abandons the transaction; no response is delivered to any port.
- States: IDLE, XFER, RESP.
- IDLE:
  - A port is requesting when its s_axi_awvalid=1. wvalid is not considered.
  - Search starts at last-grant+1 and wraps modulo PORTS. The first requester is registered into grant_idx.
  - Transition to XFER on the next edge; arbitration latency is 1 cycle.
  - No request: remain in IDLE.
- XFER: combinational muxes selected by the registered grant_idx.
  - m_axi_awvalid = s_axi_awvalid[g] & ~aw_done; s_axi_awready[g] = m_axi_awready & ~aw_done.
  - m_axi_wvalid = s_axi_wvalid[g] & ~w_done; s_axi_wready[g] = m_axi_wready & ~w_done.
  - m_axi_awaddr, m_axi_wdata and m_axi_wstrb are taken from port g.
  - m_axi_awid = grant_idx, zero-extended to ID_WIDTH.
  - AW and W may complete in either order or in the same cycle. aw_done and w_done are set on their respective handshakes.
  - When both are done (including the same cycle as the last handshake): clear both flags and go to RESP.
  - Non-granted ports see all readies at 0.
- RESP:
  - m_axi_bready = s_axi_bready[g]; s_axi_bvalid[g] = m_axi_bvalid; s_axi_bresp[g] = m_axi_bresp.
  - On the B handshake: last-grant <= g; go to IDLE.
  - The earliest regrant is 1 cycle later. Throughput is at most one write per 3 cycles.
- m_axi_bvalid seen outside RESP is ignored, and m_axi_bready stays 0.
- Without the optional feature, m_axi_bid is not checked.
- A requester deasserting awvalid after grant is a protocol violation. The block waits indefinitely.

Optional Feature:
- Macro: AXI_WR_ARB_RESP_CHECK_EN.
- Enabled, adds the following ports and checks:
  - Output resp_err_sticky (1 bit): set on any RESP handshake where m_axi_bresp != 2'b00, or where m_axi_bid != zero-extended grant_idx. Cleared only by reset.
  - Output resp_err_port (clog2(PORTS) bits): captures grant_idx on the first error only.
  - Output resp_err_count (16 bits): increments per erroneous response, saturates at 16'hFFFF.
- Disabled: none of these ports or registers exist; bresp is forwarded unchanged either way.

Test Plan:
- Port 2 alone writes addr 0x1000, strb all-ones, with AW and W in the same cycle; slave gives immediate ready and bresp=0.
  -> m_axi_awid=2, awaddr=0x1000, wlast=1; s_axi_bvalid[2] pulses with bresp=0; busy returns low; grant_idx=2.
- Ports 0-3 all request continuously.
  -> grant sequence 0,1,2,3,0. Each port gets exactly one B before any port repeats.
- Port 1 asserts W 3 cycles before AW; m_axi_awready is held low for 5 cycles.
  -> W completes first; awvalid stays high until awready; no second W beat; RESP entered one edge after the AW handshake.
- rst_n is pulled low in XFER with aw_done=1.
  -> all valids drop immediately (async). After release, port 0 has priority and no stale B reaches the old port.
- With AXI_WR_ARB_RESP_CHECK_EN defined: port 3 write gets bresp=2'b10, then port 1 gets bid=5.
  -> resp_err_sticky=1, resp_err_port=3, resp_err_count=2; s_axi_bresp[3] shows 2'b10.
